// File: rtl/hamming_secded_pkg.sv
// hamming_secded_pkg: shared (13,8) SEC-DED codeword geometry and scrubber state encoding.
package hamming_secded_pkg;
    localparam int CW_W   = 13;
    localparam int DATA_W = 8;
    localparam int PAR_N  = 4;
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};
    localparam int PAR_POS  [PAR_N]  = '{1, 2, 4, 8};
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, DONE} scrub_state_t;
endpackage

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: syndrome decode of a 13-bit codeword into corrected data and SEC/DED flags.
module hamming_secded_decoder
    import hamming_secded_pkg::*;
(
    input  logic [CW_W-1:0]   cw,
    output logic [DATA_W-1:0] data,
    output logic              sec,
    output logic              ded
);
    logic [3:0]      syn;
    logic            par;
    logic [CW_W-1:0] fixed;
    always_comb begin
        syn = '0;
        for (int j = 1; j < CW_W; j++) if (cw[j]) syn = syn ^ 4'(j);
    end
    assign par = ^cw;
    // Odd parity with a syndrome past the last position is a multi-bit error.
    assign sec = par && syn < 4'(CW_W);
    assign ded = par ? syn >= 4'(CW_W) : syn != '0;
    assign fixed = sec ? cw ^ (CW_W'(1) << syn) : cw;
    always_comb begin
        data = '0;
        for (int i = 0; i < DATA_W; i++) data[i] = fixed[DATA_POS[i]];
    end
endmodule

// File: rtl/hamming_secded_encoder.sv
// hamming_secded_encoder: 8-bit data to 13-bit SEC-DED codeword, bit 0 is overall even parity.
module hamming_secded_encoder
    import hamming_secded_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CW_W-1:0]   cw
);
    logic [CW_W-1:1] body;
    always_comb begin
        body = '0;
        for (int i = 0; i < DATA_W; i++) body[DATA_POS[i]] = data[i];
        for (int k = 0; k < PAR_N; k++)
            for (int i = 0; i < DATA_W; i++)
                if ((DATA_POS[i] & PAR_POS[k]) != 0) body[PAR_POS[k]] = body[PAR_POS[k]] ^ data[i];
    end
    assign cw = {body, ^body};
endmodule

// File: rtl/hamming_secded_scrubber.sv
// hamming_secded_scrubber: walks the memory once per start, rewrites correctable words,
// counts SEC/DED events and remembers the last uncorrectable address.
module hamming_secded_scrubber
    import hamming_secded_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CW_W-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic [CW_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count,
    output logic              ded_seen,
    output logic [ADDR_W-1:0] last_ded_addr
);
    scrub_state_t      state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [CW_W-1:0]   cw_q;
    logic [DATA_W-1:0] data;
    logic              sec, ded, last, adv;

    hamming_secded_decoder u_dec (.cw(cw_q), .data(data), .sec(sec), .ded(ded));
    // cw_q only changes in RD_WAIT, so wdata is stable across any WR_REQ stall.
    hamming_secded_encoder u_enc (.data(data), .cw(mem_wdata));

    assign last      = addr == ADDR_W'(DEPTH - 1);
    assign adv       = (state == CHECK && !sec) || (state == WR_REQ && mem_gnt);
    assign busy      = state != IDLE && state != DONE;
    assign done      = state == DONE;
    assign mem_req   = state == RD_REQ || state == WR_REQ;
    assign mem_we    = state == WR_REQ;
    assign mem_addr  = addr;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? RD_REQ : IDLE;
            RD_REQ:  state_n = mem_gnt ? RD_WAIT : RD_REQ;
            RD_WAIT: state_n = CHECK;
            CHECK:   state_n = sec ? WR_REQ : (last ? DONE : RD_REQ);
            WR_REQ:  state_n = mem_gnt ? (last ? DONE : RD_REQ) : WR_REQ;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            cw_q          <= '0;
            sec_count     <= '0;
            ded_count     <= '0;
            ded_seen      <= 1'b0;
            last_ded_addr <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                addr          <= '0;
                sec_count     <= '0;
                ded_count     <= '0;
                ded_seen      <= 1'b0;
                last_ded_addr <= '0;
            end
            if (state == RD_WAIT) cw_q <= mem_rdata;
            if (state == CHECK && sec && sec_count != '1) sec_count <= sec_count + 1'b1;
            if (state == CHECK && ded) begin
                if (ded_count != '1) ded_count <= ded_count + 1'b1;
                ded_seen      <= 1'b1;
                last_ded_addr <= addr;
            end
            if (adv && !last) addr <= addr + 1'b1;
        end
    end
endmodule

// File: tb/tb_hamming_secded_scrubber.sv
// tb_hamming_secded_scrubber: memory/arbiter responder plus a distance-based reference model
// that predicts every access, the counters and the scrubbed memory image for each pass.
module tb_hamming_secded_scrubber;
    localparam int DEPTH = 4, ADDR_W = 8, CNT_W = 2, SAT = (1 << CNT_W) - 1;

    logic              clk = 0, rst_n = 0, start = 0, mem_gnt = 0;
    logic [12:0]       mem_rdata = '0;
    logic              busy, done, mem_req, mem_we, ded_seen;
    logic [ADDR_W-1:0] mem_addr, last_ded_addr;
    logic [12:0]       mem_wdata;
    logic [CNT_W-1:0]  sec_count, ded_count;

    hamming_secded_scrubber #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .sec_count(sec_count), .ded_count(ded_count),
        .ded_seen(ded_seen), .last_ded_addr(last_ded_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [7:0] addr; logic [12:0] wdata;} acc_t;

    int          checks = 0, errors = 0;
    logic [12:0] mem [256];
    logic [12:0] exp_img [DEPTH];
    acc_t        exp_q [$];
    int          exp_sec, exp_ded, exp_seen, exp_last, exp_cycles;
    int          stall_mode = 0, done_seen = 0, run_cyc = 0, last_lat = 0, writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // A codeword is any word whose set-bit indices XOR to zero over [12:1], plus even overall parity.
    function automatic logic [12:0] enc(input logic [7:0] d);
        int          pos [8];
        logic [12:0] w;
        logic [3:0]  syn;
        pos = '{3, 5, 6, 7, 9, 10, 11, 12};
        w = '0;
        for (int i = 0; i < 8; i++) w[pos[i]] = d[i];
        for (int c = 0; c < 16; c++) begin
            w[1] = c[0]; w[2] = c[1]; w[4] = c[2]; w[8] = c[3];
            syn = '0;
            for (int j = 1; j < 13; j++) if (w[j]) syn = syn ^ 4'(j);
            if (syn == 0) break;
        end
        w[0] = ^w[12:1];
        return w;
    endfunction

    // 0 = codeword, 1 = one bit from a codeword (fix), 2 = further away.
    function automatic int classify(input logic [12:0] w, output logic [12:0] fix);
        logic [12:0] c;
        fix = w;
        for (int d = 0; d < 256; d++) begin
            c = enc(8'(d));
            if (c == w) return 0;
            if ($countones(c ^ w) == 1) begin
                fix = c;
                return 1;
            end
        end
        return 2;
    endfunction

    task automatic prepare();
        logic [12:0] f;
        int          k;
        exp_q.delete();
        exp_sec = 0; exp_ded = 0; exp_seen = 0; exp_last = 0; exp_cycles = 0;
        for (int a = 0; a < DEPTH; a++) begin
            k = classify(mem[a], f);
            exp_img[a] = f;
            exp_q.push_back('{1'b0, 8'(a), 13'h0});
            exp_cycles += (k == 1) ? 4 : 3;
            if (k == 1) begin
                exp_q.push_back('{1'b1, 8'(a), f});
                exp_sec = exp_sec < SAT ? exp_sec + 1 : SAT;
            end
            if (k == 2) begin
                exp_ded = exp_ded < SAT ? exp_ded + 1 : SAT;
                exp_seen = 1;
                exp_last = a;
            end
        end
    endtask

    task automatic load_clean();
        for (int a = 0; a < DEPTH; a++) mem[a] = enc(8'($urandom));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic run_pass(input bit extra_start);
        int n, t;
        n = done_seen;
        t = 0;
        prepare();
        writes = 0;
        pulse_start();
        if (extra_start) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1 start = 1;
            @(posedge clk); #1 start = 0;
        end
        while (done_seen == n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("done_timeout", done_seen - n, 1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_sec", sec_count, exp_sec);
        check("hold_ded", ded_count, exp_ded);
        check("hold_busy", busy, 0);
        for (int a = 0; a < DEPTH; a++) check($sformatf("image[%0d]", a), mem[a], exp_img[a]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_sec"}, sec_count, 0);
        check({tag, "_ded"}, ded_count, 0);
        check({tag, "_seen"}, ded_seen, 0);
        check({tag, "_last"}, last_ded_addr, 0);
    endtask

    // Memory/arbiter responder and the per-cycle compare against the model.
    initial begin : bus
        acc_t        cur, prev, e;
        logic        prev_stall, rd_pend;
        logic [7:0]  rd_addr;
        int          wt, need;
        prev_stall = 0; rd_pend = 0; rd_addr = 0; wt = 0; need = 0; prev = '0;
        forever begin
            @(negedge clk);
            if (rd_pend) mem_rdata = mem[rd_addr];
            rd_pend = 0;
            if (!rst_n) begin
                mem_gnt = 0; wt = 0; prev_stall = 0; run_cyc = 0;
            end else begin
                cur = '{mem_we, mem_addr, mem_wdata};
                if (busy) run_cyc++;
                if (!busy) check("idle_req", mem_req, 0);
                if (prev_stall) begin
                    check("stall_req", mem_req, 1);
                    check("stall_bus", 32'(cur), 32'(prev));
                end
                if (mem_req) begin
                    if (wt == 0) need = stall_mode == 1 ? 5 : stall_mode == 2 ? int'($urandom_range(0, 3)) : 0;
                    mem_gnt = wt >= need;
                    if (mem_gnt) begin
                        if (exp_q.size() == 0) check("extra_access", {mem_we, mem_addr}, 0);
                        else begin
                            e = exp_q.pop_front();
                            check("acc_we", mem_we, e.we);
                            check("acc_addr", mem_addr, e.addr);
                            if (e.we) check("acc_wdata", mem_wdata, e.wdata);
                        end
                        if (mem_we) begin
                            mem[mem_addr] = mem_wdata;
                            writes++;
                        end else begin
                            rd_pend = 1;
                            rd_addr = mem_addr;
                        end
                        wt = 0;
                    end else wt++;
                    prev_stall = !mem_gnt;
                    prev = cur;
                end else begin
                    mem_gnt = stall_mode == 0;
                    wt = 0;
                    prev_stall = 0;
                end
                if (done) begin
                    check("done_busy", busy, 0);
                    check("done_pending", exp_q.size(), 0);
                    check("done_sec", sec_count, exp_sec);
                    check("done_ded", ded_count, exp_ded);
                    check("done_seen", ded_seen, exp_seen);
                    check("done_last", last_ded_addr, exp_last);
                    if (stall_mode == 0) check("latency", run_cyc, exp_cycles);
                    last_lat = run_cyc;
                    run_cyc = 0;
                    done_seen++;
                end
            end
        end
    end

    initial begin : main
        logic [12:0] f, bad;
        int          k, t, b1, b2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1;

        check("enc_A5", enc(8'hA5), 13'h144E);
        check("enc_FF", enc(8'hFF), 13'h1EEE);
        k = classify(13'h144E ^ 13'h0040, f);
        check("cls_sec", k, 1);
        check("cls_fix", f, 13'h144E);
        k = classify(13'h144E ^ 13'h0220, f);
        check("cls_ded", k, 2);

        stall_mode = 0;
        load_clean();
        run_pass(0);
        check("s1_writes", writes, 0);
        check("s1_latency", last_lat, 12);
        check("s1_sec", sec_count, 0);

        for (int m = 0; m < 2; m++) begin
            stall_mode = m;
            load_clean();
            mem[2] = enc(8'hA5) ^ 13'h0040;
            run_pass(0);
            check("s2_writes", writes, 1);
            check("s2_word", mem[2], 13'h144E);
            check("s2_sec", sec_count, 1);
            check("s2_ded", ded_count, 0);
        end
        stall_mode = 0;

        load_clean();
        mem[1] = enc(8'h3C) ^ 13'h0001;
        run_pass(0);
        check("s3_writes", writes, 1);
        check("s3_word", mem[1], enc(8'h3C));
        check("s3_sec", sec_count, 1);

        load_clean();
        mem[3] = enc(8'h5A) ^ 13'h0220;
        bad = mem[3];
        run_pass(0);
        check("s4_writes", writes, 0);
        check("s4_word", mem[3], bad);
        check("s4_ded", ded_count, 1);
        check("s4_seen", ded_seen, 1);
        check("s4_last", last_ded_addr, 3);

        stall_mode = 1;
        load_clean();
        mem[0] = enc(8'h81) ^ 13'h0400;
        bad = mem[0];
        prepare();
        writes = 0;
        pulse_start();
        t = 0;
        while (!(mem_req && mem_we) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("s6_wr_reached", mem_req & mem_we, 1);
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("s6");
        check("s6_nowrite", mem[0], bad);
        check("s6_writes", writes, 0);
        @(posedge clk); #1 rst_n = 1;
        stall_mode = 0;
        run_pass(0);
        check("s6_sec", sec_count, 1);
        check("s6_word", mem[0], enc(8'h81));

        for (int a = 0; a < DEPTH; a++) mem[a] = enc(8'($urandom)) ^ (13'h1 << $urandom_range(0, 12));
        run_pass(0);
        check("sat_sec", sec_count, 3);
        for (int a = 0; a < DEPTH; a++) mem[a] = enc(8'($urandom)) ^ 13'h0006;
        run_pass(0);
        check("sat_ded", ded_count, 3);
        check("sat_last", last_ded_addr, 3);

        for (int p = 0; p < 20; p++) begin
            stall_mode = $urandom_range(0, 2);
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] = enc(8'($urandom));
                k = $urandom_range(0, 2);
                b1 = $urandom_range(0, 12);
                b2 = (b1 + 1 + int'($urandom_range(0, 11))) % 13;
                if (k >= 1) mem[a] = mem[a] ^ (13'h1 << b1);
                if (k == 2) mem[a] = mem[a] ^ (13'h1 << b2);
            end
            run_pass(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
